// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, I-cache read port and IF/ID pipeline register.
// Cache misses freeze the stage; ID redirects flush IF/ID to a single bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        PCWrite_i,
    input  logic        IF_ID_Write_i,
    input  logic        ID_BranchTaken_i,
    input  logic [31:0] ID_BranchTarget_i,
    output logic        ICACHE_ren_o,
    output logic [29:0] ICACHE_addr_o,
    input  logic        ICACHE_stall_i,
    input  logic [31:0] ICACHE_rdata_i,
    output logic [31:0] IF_ID_pc_o,
    output logic [31:0] IF_ID_inst_o,
    output logic        IF_ID_valid_o,
    output logic        Fetch_stall_o,
    output logic [31:0] Perf_fetch_cnt_o,
    output logic [31:0] Perf_miss_cnt_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ADDRW = 30;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_MISS  = 2'd2
    } fetchStateT;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
    } ifIdT;

    fetchStateT      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic            ren;
    logic            redirect;
    ifIdT            ifId;
    logic [XLEN-1:0] fetchCnt;
    logic [XLEN-1:0] missCnt;

    // Stall is visible in the request cycle so downstream stages freeze on the same edge.
    assign Fetch_stall_o = ICACHE_stall_i & ren;
    assign redirect      = ID_BranchTaken_i & PCWrite_i;
    assign pcPlus4       = pc + XLEN'(4);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_BOOT;
            ren      <= 1'b0;
            pc       <= RESET_PC;
            ifId     <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
            fetchCnt <= '0;
            missCnt  <= '0;
        end else begin
            case (state)
                S_BOOT: begin
                    state <= S_FETCH;
                    ren   <= 1'b1;
                end
                default: begin
                    if (Fetch_stall_o) begin
                        // Miss in flight: everything holds, redirect is re-presented later.
                        state   <= S_MISS;
                        missCnt <= missCnt + XLEN'(1);
                    end else begin
                        state <= S_FETCH;
                        if (redirect) begin
                            pc   <= ID_BranchTarget_i;
                            ifId <= '{pc: pc, inst: NOP_INST, valid: 1'b0};
                        end else begin
                            if (PCWrite_i) begin
                                pc <= pcPlus4;
                            end
                            if (IF_ID_Write_i) begin
                                ifId     <= '{pc: pc, inst: ICACHE_rdata_i, valid: 1'b1};
                                fetchCnt <= fetchCnt + XLEN'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign ICACHE_ren_o     = ren;
    assign ICACHE_addr_o    = ADDRW'(pc >> 2);
    assign IF_ID_pc_o       = ifId.pc;
    assign IF_ID_inst_o     = ifId.inst;
    assign IF_ID_valid_o    = ifId.valid;
    assign Perf_fetch_cnt_o = fetchCnt;
    assign Perf_miss_cnt_o  = missCnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        PCWrite_i = 1'b1;
    logic        IF_ID_Write_i = 1'b1;
    logic        ID_BranchTaken_i = 1'b0;
    logic [31:0] ID_BranchTarget_i = '0;
    logic        ICACHE_ren_o;
    logic [29:0] ICACHE_addr_o;
    logic        ICACHE_stall_i = 1'b0;
    logic [31:0] ICACHE_rdata_i = '0;
    logic [31:0] IF_ID_pc_o;
    logic [31:0] IF_ID_inst_o;
    logic        IF_ID_valid_o;
    logic        Fetch_stall_o;
    logic [31:0] Perf_fetch_cnt_o;
    logic [31:0] Perf_miss_cnt_o;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .PCWrite_i        (PCWrite_i),
        .IF_ID_Write_i    (IF_ID_Write_i),
        .ID_BranchTaken_i (ID_BranchTaken_i),
        .ID_BranchTarget_i(ID_BranchTarget_i),
        .ICACHE_ren_o     (ICACHE_ren_o),
        .ICACHE_addr_o    (ICACHE_addr_o),
        .ICACHE_stall_i   (ICACHE_stall_i),
        .ICACHE_rdata_i   (ICACHE_rdata_i),
        .IF_ID_pc_o       (IF_ID_pc_o),
        .IF_ID_inst_o     (IF_ID_inst_o),
        .IF_ID_valid_o    (IF_ID_valid_o),
        .Fetch_stall_o    (Fetch_stall_o),
        .Perf_fetch_cnt_o (Perf_fetch_cnt_o),
        .Perf_miss_cnt_o  (Perf_miss_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: "booted" flag, PC, IF/ID contents and the two counters.
    bit          mBooted;
    logic [31:0] mPc, mIfPc, mIfInst, mFetch, mMiss;
    bit          mIfValid;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] byteAddr);
        return (byteAddr * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic modelStep(input bit rst, input bit pcw, input bit ifw, input bit tk,
                             input logic [31:0] tgt, input bit st, input logic [31:0] rdata);
        if (rst) begin
            mBooted = 0; mPc = RESET_PC;
            mIfPc = 0; mIfInst = NOP_INST; mIfValid = 0;
            mFetch = 0; mMiss = 0;
        end else if (!mBooted) begin
            mBooted = 1;
        end else if (st) begin
            mMiss = mMiss + 1;
        end else if (tk && pcw) begin
            mIfPc = mPc; mIfInst = NOP_INST; mIfValid = 0;
            mPc = tgt;
        end else begin
            if (ifw) begin
                mIfPc = mPc; mIfInst = rdata; mIfValid = 1;
                mFetch = mFetch + 1;
            end
            if (pcw) mPc = mPc + 32'd4;
        end
    endtask

    task automatic doCycle(input bit rst, input bit pcw, input bit ifw, input bit tk,
                           input logic [31:0] tgt, input bit st);
        logic [31:0] rdata;
        @(negedge clk);
        rdata = st ? $urandom : memWord(mPc);
        rst_i = rst; PCWrite_i = pcw; IF_ID_Write_i = ifw;
        ID_BranchTaken_i = tk; ID_BranchTarget_i = tgt;
        ICACHE_stall_i = st; ICACHE_rdata_i = rdata;
        #1;
        checkEq("fetch_stall", 32'(Fetch_stall_o), 32'(st & mBooted));
        modelStep(rst, pcw, ifw, tk, tgt, st & mBooted, rdata);
        @(posedge clk);
        #1;
        checkEq("ren", 32'(ICACHE_ren_o), 32'(mBooted));
        checkEq("addr", 32'(ICACHE_addr_o), mPc >> 2);
        checkEq("if_pc", IF_ID_pc_o, mIfPc);
        checkEq("if_inst", IF_ID_inst_o, mIfInst);
        checkEq("if_valid", 32'(IF_ID_valid_o), 32'(mIfValid));
        checkEq("fetch_cnt", Perf_fetch_cnt_o, mFetch);
        checkEq("miss_cnt", Perf_miss_cnt_o, mMiss);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) doCycle(0, 1, 1, 0, 0, 0);
    endtask

    initial begin
        int missLeft;
        bit st;
        mBooted = 0; mPc = RESET_PC; mIfPc = 0; mIfInst = NOP_INST;
        mIfValid = 0; mFetch = 0; mMiss = 0;

        // Reset and boot cycle
        doCycle(1, 1, 1, 0, 0, 0);
        checkEq("rst_ren", 32'(ICACHE_ren_o), 32'd0);
        checkEq("rst_inst", IF_ID_inst_o, NOP_INST);
        doCycle(0, 1, 1, 0, 0, 0);
        checkEq("boot_addr", 32'(ICACHE_addr_o), 32'd0);

        // Three hits: pc 0,4,8
        run(3);
        checkEq("hit_pc8", IF_ID_pc_o, 32'h8);
        checkEq("hit_cnt3", Perf_fetch_cnt_o, 32'd3);

        // Load-use stall at PC=0x10
        run(1);
        doCycle(0, 0, 0, 0, 0, 0);
        checkEq("lu_addr", 32'(ICACHE_addr_o), 32'h4);
        checkEq("lu_ifpc", IF_ID_pc_o, 32'hC);
        run(1);
        checkEq("lu_resume", IF_ID_pc_o, 32'h10);

        // Redirect at PC=0x20 to 0x100
        run(3);
        doCycle(0, 1, 1, 1, 32'h100, 0);
        checkEq("br_pc", IF_ID_pc_o, 32'h20);
        checkEq("br_bubble", 32'(IF_ID_valid_o), 32'd0);
        run(1);
        checkEq("br_tgt", IF_ID_pc_o, 32'h100);
        checkEq("br_valid", 32'(IF_ID_valid_o), 32'd1);

        // 5-cycle miss at 0x40 with a redirect pending throughout
        doCycle(0, 1, 1, 1, 32'h40, 0);
        for (int i = 0; i < 5; i++) begin
            doCycle(0, 1, 1, 1, 32'h200, 1);
            checkEq("miss_addr", 32'(ICACHE_addr_o), 32'h10);
        end
        checkEq("miss_cnt5", Perf_miss_cnt_o, 32'd5);
        doCycle(0, 1, 1, 1, 32'h200, 0);
        checkEq("miss_redir", 32'(ICACHE_addr_o), 32'h80);
        checkEq("miss_ifpc", IF_ID_pc_o, 32'h40);

        // Redirect ignored while PCWrite is low
        doCycle(0, 0, 0, 1, 32'h300, 0);
        checkEq("nopcw_addr", 32'(ICACHE_addr_o), 32'h80);
        checkEq("nopcw_ifpc", IF_ID_pc_o, 32'h40);

        // PC wrap
        run(1);
        doCycle(0, 1, 1, 1, 32'hFFFF_FFFC, 0);
        run(1);
        checkEq("wrap_addr", 32'(ICACHE_addr_o), 32'd0);
        checkEq("wrap_ifpc", IF_ID_pc_o, 32'hFFFF_FFFC);

        // Reset in cycle 2 of a miss; late response ignored
        doCycle(0, 1, 1, 0, 0, 1);
        doCycle(1, 1, 1, 0, 0, 1);
        checkEq("rmiss_ren", 32'(ICACHE_ren_o), 32'd0);
        checkEq("rmiss_miss", Perf_miss_cnt_o, 32'd0);
        checkEq("rmiss_fetch", Perf_fetch_cnt_o, 32'd0);
        doCycle(0, 1, 1, 0, 0, 1);

        // Random traffic
        missLeft = 0;
        for (int i = 0; i < 2000; i++) begin
            if (missLeft == 0 && $urandom_range(0, 99) < 12) missLeft = $urandom_range(1, 5);
            st = (missLeft > 0);
            if (missLeft > 0) missLeft--;
            doCycle($urandom_range(0, 199) == 0,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) == 0,
                    {$urandom, 2'b00} >> 0 & 32'hFFFF_FFFC,
                    st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the PC register, drives the instruction-cache read port and holds the IF/ID pipeline register. It sits directly upstream of the hazard-detection unit and consumes that unit's `PCWrite`/`IF_ID_Write` stall controls. It also takes the branch redirect resolved in ID and the I-cache miss stall. It produces the IF/ID outputs read by decode, plus a global freeze signal and two performance counters.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INST`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, synchronous and active-high.
- `PCWrite_i` in 1: 0 means hold PC (load-use stall).
- `IF_ID_Write_i` in 1: 0 means hold the IF/ID register.
- `ID_BranchTaken_i` in 1: taken branch/jump resolved in ID.
- `ID_BranchTarget_i` in 32: redirect target, word aligned.
- `ICACHE_ren_o` out 1: read request.
- `ICACHE_addr_o` out 30: word address, equal to PC[31:2].
- `ICACHE_stall_i` in 1: miss in progress; valid combinationally in the request cycle.
- `ICACHE_rdata_i` in 32: instruction, valid in any cycle with ren=1 and stall=0.
- `IF_ID_pc_o` out 32: PC of the instruction in IF/ID.
- `IF_ID_inst_o` out 32: instruction in IF/ID.
- `IF_ID_valid_o` out 1: 0 means IF/ID holds a bubble.
- `Fetch_stall_o` out 1: freezes all pipeline registers downstream.
- `Perf_fetch_cnt_o` out 32: count of instructions written into IF/ID with valid=1; wraps.
- `Perf_miss_cnt_o` out 32: count of cycles spent in `S_MISS`; wraps.

## Operation
- FSM states:
  - `S_BOOT`: one cycle after reset; ren=0; then goes to `S_FETCH`.
  - `S_FETCH`: ren=1. Goes to `S_MISS` when `ICACHE_stall_i`=1.
  - `S_MISS`: ren=1, address unchanged. Returns to `S_FETCH` in the first cycle with stall=0; that cycle is treated as a normal `S_FETCH` cycle.
- `Fetch_stall_o` = `ICACHE_stall_i` & ren. It is combinational.
- Per-cycle update priority, highest first:
  1. `rst_i`: PC=RESET_PC; IF/ID = {pc 0, NOP_INST, valid 0}; both counters 0; state `S_BOOT`.
  2. `S_BOOT`: PC and IF/ID hold.
  3. Cache stall (`Fetch_stall_o`=1): PC, IF/ID, and the redirect inputs are all ignored and held; `Perf_miss_cnt_o`+1.
  4. Redirect (`ID_BranchTaken_i`=1 and `PCWrite_i`=1): PC=target. IF/ID is flushed to {current PC, NOP_INST, valid 0} regardless of `IF_ID_Write_i`. The fetched instruction is discarded.
  5. Otherwise, PC and IF/ID update independently:
     - PC: PC+4 when `PCWrite_i`=1; hold when 0.
     - IF/ID: load {PC, rdata, valid 1} when `IF_ID_Write_i`=1; hold when 0.
- A redirect with `PCWrite_i`=0 is ignored. The branch stays in ID and is re-presented in a later cycle.
- PC+4 is 32-bit modular: 0xFFFF_FFFC wraps to 0.
- `Perf_fetch_cnt_o` increments only when IF/ID loads with valid=1.

## Timing
- Reset values of all outputs:
  - `ICACHE_ren_o`=0, `ICACHE_addr_o`=RESET_PC[31:2].
  - `IF_ID_pc_o`=0, `IF_ID_inst_o`=NOP_INST, `IF_ID_valid_o`=0.
  - `Fetch_stall_o`=0, both counters 0.
- Hit latency: the instruction at PC appears on the IF/ID outputs one edge after the request cycle.
- Taken-branch penalty: exactly one bubble. The target's request is issued in the cycle after the redirect.
- A miss of N stall cycles freezes IF/ID for N cycles and adds N to `Perf_miss_cnt_o`. The address is held constant throughout.
- A stall and a redirect in the same cycle: the stall wins. Because ID is frozen, the redirect is re-presented and takes effect in the first stall-free cycle.
- Reset during `S_MISS` aborts immediately. ren goes low for the next cycle; any late cache response is ignored.

## Test plan
- Reset, then hits on all fetches:
  - ren=0 in the first cycle.
  - Addresses 0,1,2,… appear, one per cycle.
  - IF/ID shows pc 0x0, 0x4, 0x8 with valid=1.
  - After 3 instructions, `Perf_fetch_cnt_o`=3.
- Load-use stall, with PCWrite_i=IF_ID_Write_i=0 for 1 cycle at PC=0x10:
  - PC holds 0x10 for that cycle.
  - IF/ID holds pc 0xC.
  - Next cycle resumes with 0x10 → 0x14.
- Redirect at PC=0x20 with target 0x100:
  - The next IF/ID is {0x20, NOP_INST, valid 0}.
  - The following IF/ID has pc 0x100, valid 1.
- 5-cycle miss at PC=0x40, with a redirect asserted during the miss:
  - `Fetch_stall_o`=1 for 5 cycles, and `ICACHE_addr_o` stays 0x10.
  - `Perf_miss_cnt_o`=5.
  - The redirect takes effect on the first stall-free cycle.
- Redirect with PCWrite_i=0: PC and IF/ID are unchanged.
- Wrap and reset mid-miss:
  - PC=0xFFFF_FFFC advances to 0x0.
  - Asserting `rst_i` in cycle 2 of a miss gives PC=RESET_PC, ren=0, and both counters 0 on the next cycle.
